// File: rtl/fetch_ctrl_if.sv
// Fetch-controller bundle: hazard/redirect inputs from the pipeline and the
// PC / pipeline-register controls driven back by fetch_ctrl.
interface fetch_ctrl_if;
    logic        imem_ready;
    logic        br_taken_ex;
    logic [31:0] br_target_ex;
    logic        trap_req;
    logic [31:0] trap_vec;
    logic        ld_use_stall;
    logic        halt_req;
    logic        resume;
    logic        pc_en;
    logic        pc_sel;
    logic [31:0] pc_redirect;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        halted;
    logic [31:0] stall_cnt;
    logic [31:0] redir_cnt;

    modport master (
        input  imem_ready, br_taken_ex, br_target_ex, trap_req, trap_vec,
               ld_use_stall, halt_req, resume,
        output pc_en, pc_sel, pc_redirect, ifid_en, ifid_flush, idex_flush,
               halted, stall_cnt, redir_cnt
    );

    modport slave (
        output imem_ready, br_taken_ex, br_target_ex, trap_req, trap_vec,
               ld_use_stall, halt_req, resume,
        input  pc_en, pc_sel, pc_redirect, ifid_en, ifid_flush, idex_flush,
               halted, stall_cnt, redir_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Front-end controller: arbitrates PC redirects, applies load-use and imem
// wait-state stalls, holds pending redirects and implements a debug halt.
module fetch_ctrl (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [1:0]  RUN  = 2'd0;
    localparam logic [1:0]  PEND = 2'd1;
    localparam logic [1:0]  HALT = 2'd2;

    logic [1:0]  state, state_d;
    logic [31:0] pend_r, pend_d;
    logic [31:0] stall_r, redir_r;
    logic        redir_inc;
    logic        redir_any;
    logic [31:0] target;

    logic        pc_en, pc_sel, ifid_en, ifid_flush, idex_flush;
    logic [31:0] pc_redirect;

    assign redir_any = bus.trap_req | bus.br_taken_ex;
    assign target    = bus.trap_req ? bus.trap_vec : bus.br_target_ex;

    always_comb begin
        state_d     = state;
        pend_d      = pend_r;
        redir_inc   = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = 1'b0;
        pc_redirect = RESET_PC;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        case (state)
            RUN: begin
                if (redir_any) begin
                    pc_sel      = 1'b1;
                    pc_redirect = target;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    redir_inc   = 1'b1;
                    if (bus.imem_ready) begin
                        pc_en = 1'b1;
                    end else begin
                        pend_d  = target;
                        state_d = PEND;
                    end
                end else begin
                    // load-use wins over an imem wait: hold IF/ID rather than flush it
                    if (bus.ld_use_stall) begin
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end else if (!bus.imem_ready) begin
                        ifid_flush = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                    end
                    if (bus.halt_req) state_d = HALT;
                end
            end
            PEND: begin
                pc_sel      = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                pc_en       = bus.imem_ready;
                pc_redirect = pend_r;
                if (bus.trap_req) begin
                    pc_redirect = bus.trap_vec;
                    pend_d      = bus.trap_vec;
                    redir_inc   = 1'b1;
                end
                if (bus.imem_ready) state_d = RUN;
            end
            HALT: begin
                ifid_flush = 1'b1;
                if (bus.trap_req) begin
                    pc_sel      = 1'b1;
                    pc_redirect = bus.trap_vec;
                    idex_flush  = 1'b1;
                    redir_inc   = 1'b1;
                    if (bus.imem_ready) begin
                        pc_en   = 1'b1;
                        state_d = RUN;
                    end else begin
                        pend_d  = bus.trap_vec;
                        state_d = PEND;
                    end
                end else if (bus.resume) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            pend_r  <= '0;
            stall_r <= '0;
            redir_r <= '0;
        end else begin
            state  <= state_d;
            pend_r <= pend_d;
            if (state != HALT && !pc_en) stall_r <= stall_r + 32'd1;
            if (redir_inc)               redir_r <= redir_r + 32'd1;
        end
    end

    // Controls are forced quiet while reset is held, independent of state.
    assign bus.pc_en       = rst ? 1'b0 : pc_en;
    assign bus.pc_sel      = rst ? 1'b0 : pc_sel;
    assign bus.pc_redirect = rst ? RESET_PC : pc_redirect;
    assign bus.ifid_en     = rst ? 1'b0 : ifid_en;
    assign bus.ifid_flush  = rst ? 1'b0 : ifid_flush;
    assign bus.idex_flush  = rst ? 1'b0 : idex_flush;
    assign bus.halted      = !rst && (state == HALT);
    assign bus.stall_cnt   = stall_r;
    assign bus.redir_cnt   = redir_r;
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Pipeline front-end controller that sequences the fetch stage's PC register and the IF/ID and ID/EX pipeline registers. It arbitrates PC redirect sources (trap, taken branch from EX), applies load-use stalls and instruction-memory wait states, and inserts bubbles. It holds a pending redirect across memory wait states and provides a debug halt. It sits beside the fetch stage; its outputs drive the PC load enable, the PC next-address select and the pipeline register enable/flush controls.

## Interface
- RESET_PC, 32'h00000000, reported on `pc_redirect` while idle; not loaded by this block.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- imem_ready  in  1  instruction memory accepts a new address and returns the data for the current one this cycle.
- br_taken_ex  in  1  taken branch/jump resolved in EX.
- br_target_ex  in  32  branch target.
- trap_req  in  1  trap/exception redirect request.
- trap_vec  in  32  trap handler address.
- ld_use_stall  in  1  load-use hazard detected in decode.
- halt_req  in  1  debug halt request (level).
- resume  in  1  leave HALT (1-cycle pulse).
- pc_en  out  1  PC register load enable.
- pc_sel  out  1  0 = PC+4, 1 = `pc_redirect`.
- pc_redirect  out  32  redirect address.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID loads a NOP (has priority over ifid_en).
- idex_flush  out  1  ID/EX loads a bubble.
- halted  out  1  state == HALT.
- stall_cnt  out  32  count of non-halted cycles with pc_en = 0.
- redir_cnt  out  32  count of redirects accepted.

## Operation
- States: RUN, PEND, HALT. Registers: state, pend_r[31:0], stall_cnt, redir_cnt.
- All control outputs are combinational from state, pend_r and inputs in the same cycle. Defaults: pc_en = 0, pc_sel = 0, pc_redirect = RESET_PC, ifid_en = 1, all flushes = 0.
- Redirect selection: trap_req beats br_taken_ex. The target is trap_vec or br_target_ex.
- RUN, redirect present:
  - pc_sel = 1, pc_redirect = target, ifid_flush = 1, idex_flush = 1.
  - If imem_ready: pc_en = 1; stay in RUN.
  - Else: pc_en = 0, pend_r <= target, go to PEND.
  - redir_cnt increments once per redirect.
- RUN, no redirect, ld_use_stall: pc_en = 0, ifid_en = 0, idex_flush = 1. This holds even when imem_ready = 0.
- RUN, no redirect, no ld_use_stall, imem_ready = 0: pc_en = 0, ifid_flush = 1.
- RUN, otherwise: pc_en = 1, pc_sel = 0.
- RUN to HALT: halt_req with no redirect this cycle. The halt takes effect on the next cycle; the current cycle behaves per the rules above.
- PEND:
  - pc_sel = 1, pc_redirect = pend_r, ifid_flush = 1, idex_flush = 1, pc_en = imem_ready.
  - When imem_ready, go to RUN.
  - trap_req in PEND overwrites the target (trap_vec is used combinationally this cycle and loaded into pend_r if still waiting) and increments redir_cnt.
  - br_taken_ex in PEND is ignored (wrong-path bubble).
- HALT:
  - pc_en = 0, ifid_flush = 1.
  - resume: go to RUN next cycle.
  - trap_req: handled as in RUN (to RUN or PEND), takes priority over resume.
  - halt_req is ignored while in HALT.
- stall_cnt increments in every RUN/PEND cycle with pc_en = 0. redir_cnt increments as above. Both wrap modulo 2^32.

## Timing
- Reset (async assert, sync release) gives state = RUN, pend_r = 0, counters = 0.
- While rst = 1: pc_en = 0, pc_sel = 0, pc_redirect = RESET_PC, ifid_en = 0, ifid_flush = 0, idex_flush = 0, halted = 0.
- Redirect latency: target is in the PC at the edge closing the first cycle with imem_ready = 1. Zero extra cycles when the memory is ready.
- Load-use stall: one bubble per cycle ld_use_stall is high.
- Reset mid-PEND discards pend_r. The first cycle after reset release is a normal RUN fetch.

## Test plan
- Reset: assert rst mid-PEND with pend_r = 0x80 -> all outputs at reset values, state RUN, counters 0. After release with imem_ready = 1 and no requests -> pc_en = 1, pc_sel = 0.
- Branch, ready memory: br_taken_ex = 1, br_target_ex = 0x40, imem_ready = 1 -> same cycle pc_en = 1, pc_sel = 1, pc_redirect = 0x40, both flushes = 1; redir_cnt = 1.
- Branch during wait: branch to 0x40 with imem_ready = 0 for 3 cycles -> PEND. pc_redirect = 0x40 and pc_en = 0 for 3 cycles; then pc_en = 1 on the ready cycle, back to RUN; stall_cnt = 3.
- Trap overrides in PEND: pend 0x40, then trap_req with trap_vec = 0x100 while not ready -> pc_redirect = 0x100 thereafter; redir_cnt = 2.
- Simultaneous trap + branch in RUN -> pc_redirect = trap_vec. ld_use_stall with imem_ready = 0 -> ifid_en = 0, idex_flush = 1, ifid_flush = 0.
- Halt: halt_req for 1 cycle -> halted = 1 next cycle, pc_en = 0, stall_cnt frozen. resume -> halted = 0 next cycle. trap_req in HALT with resume -> redirect to trap_vec.
